// File: rtl/bus_glue_ctrl.sv
// Accelerator bus glue: DTACK merge, fast-RAM DTACK with wait states, speed-mode switching and BG/BGACK arbitration.
// Optional bus-error timeout is built in when BUS_TIMEOUT_EN is defined.
module bus_glue_ctrl #(
  parameter int unsigned NUM_DTACK_SRC = 2,
  parameter int unsigned SPEED_W       = 1,
  parameter int unsigned WS_W          = 3,
  parameter int unsigned TIMEOUT_CYC   = 1023
) (
  input  logic                     C14M,
  input  logic                     RESET_n,
  input  logic                     C7M_EN,
  input  logic                     AS_CPU_n,
  input  logic                     DS_n,
  input  logic                     BG_n,
  input  logic                     BGACK_n,
  input  logic                     HALT_n,
  input  logic                     RAM_ACCESS,
  input  logic [WS_W-1:0]          WAIT_STATES,
  input  logic [SPEED_W-1:0]       SPEED_REQ,
  input  logic [NUM_DTACK_SRC-1:0] DTACK_SRC_n,
  input  logic                     DTACK_PIN_n,
  output logic                     DTACK_OUT,
  output logic                     DTACK_OE,
  output logic                     FAST_DTACK_n,
  output logic [SPEED_W-1:0]       CPU_SPEED,
  output logic                     SPEED_CHANGE,
  output logic                     DMAREQ_n,
  output logic                     AS_MB_EN,
  output logic                     BERR_n
);

  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_ASSERT} fast_state_t;
  typedef enum logic [1:0] {ARB_CPU, ARB_WAIT_IDLE, ARB_DMA} arb_state_t;

  fast_state_t      fast_q, fast_d;
  logic [WS_W-1:0]  ws_cnt_q, ws_cnt_d;
  arb_state_t       arb_q, arb_d;
  logic             dtack_all_n;
  logic             dtack_q;
  logic             as_hi_q;
  logic             boundary_q, boundary_d;
  logic             take_c;
  logic             bus_free;

  // Merged active-low DTACK and the open-drain style pin drive
  assign dtack_all_n = (&DTACK_SRC_n) & FAST_DTACK_n;
  assign DTACK_OUT   = dtack_all_n;
  assign DTACK_OE    = ~(dtack_all_n & DTACK_PIN_n);
  assign AS_MB_EN    = (arb_q != ARB_DMA) & BGACK_n & HALT_n;
  assign bus_free    = AS_CPU_n & dtack_all_n;

  // Fast-RAM DTACK next state
  always_comb begin
    fast_d   = fast_q;
    ws_cnt_d = ws_cnt_q;
    case (fast_q)
      F_IDLE: begin
        if (!DS_n && RAM_ACCESS && !AS_CPU_n) begin
          fast_d   = F_WAIT;
          ws_cnt_d = WAIT_STATES;
        end
      end
      F_WAIT: begin
        if (DS_n)                fast_d = F_IDLE;
        else if (ws_cnt_q == '0) fast_d = F_ASSERT;
        else                     ws_cnt_d = ws_cnt_q - WS_W'(1);
      end
      F_ASSERT: begin
        if (DS_n) fast_d = F_IDLE;
      end
      default: fast_d = F_IDLE;
    endcase
  end

  // Arbitration next state, only moves on the C7M strobe
  always_comb begin
    arb_d = arb_q;
    if (C7M_EN) begin
      case (arb_q)
        ARB_CPU: begin
          if (!BG_n) arb_d = bus_free ? ARB_DMA : ARB_WAIT_IDLE;
        end
        ARB_WAIT_IDLE: begin
          if (BG_n)          arb_d = ARB_CPU;
          else if (bus_free) arb_d = ARB_DMA;
        end
        ARB_DMA: begin
          if (BG_n) arb_d = ARB_CPU;
        end
        default: arb_d = ARB_CPU;
      endcase
    end
  end

  // A boundary is consumed by the next strobe whether or not a switch happens,
  // so a request glitch between boundaries cannot slip through later.
  assign take_c     = C7M_EN & boundary_q & (SPEED_REQ != CPU_SPEED);
  assign boundary_d = (boundary_q & ~C7M_EN)
                    | (dtack_all_n & ~dtack_q)
                    | (AS_CPU_n & as_hi_q);

  always_ff @(posedge C14M) begin
    if (!RESET_n) begin
      fast_q       <= F_IDLE;
      ws_cnt_q     <= '0;
      FAST_DTACK_n <= 1'b1;
      arb_q        <= ARB_CPU;
      DMAREQ_n     <= 1'b1;
      dtack_q      <= 1'b1;
      as_hi_q      <= 1'b0;
      boundary_q   <= 1'b0;
      CPU_SPEED    <= '0;
      SPEED_CHANGE <= 1'b0;
    end else begin
      fast_q       <= fast_d;
      ws_cnt_q     <= ws_cnt_d;
      FAST_DTACK_n <= (fast_q != F_ASSERT);
      arb_q        <= arb_d;
      DMAREQ_n     <= (arb_d != ARB_DMA);
      dtack_q      <= dtack_all_n;
      as_hi_q      <= AS_CPU_n;
      boundary_q   <= boundary_d;
      SPEED_CHANGE <= take_c;
      if (take_c) CPU_SPEED <= SPEED_REQ;
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            berr_q;

  // Bus error once a strobed cycle has waited TIMEOUT_CYC clocks without DTACK
  always_ff @(posedge C14M) begin
    if (!RESET_n || AS_CPU_n) begin
      to_cnt_q <= '0;
      berr_q   <= 1'b1;
    end else if (berr_q) begin
      if (!dtack_all_n) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
        if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) berr_q <= 1'b0;
      end
    end
  end

  assign BERR_n = berr_q;
`else
  // No timeout hardware; TIMEOUT_CYC only matters when the timeout is built in
  assign BERR_n = 1'b1 | (TIMEOUT_CYC == 0);
`endif

endmodule

// File: tb/tb_bus_glue_ctrl.sv
// Directed bench for bus_glue_ctrl: DTACK merge table plus fast-DTACK, speed-switch, arbitration and reset sequences.
// Define BUS_TIMEOUT_EN for both bench and RTL to exercise the bus-error timeout.
module tb_bus_glue_ctrl;

  logic       C14M;
  logic       RESET_n;
  logic       c7m_en;
  logic       AS_CPU_n;
  logic       DS_n;
  logic       BG_n;
  logic       BGACK_n;
  logic       HALT_n;
  logic       RAM_ACCESS;
  logic [2:0] WAIT_STATES;
  logic [0:0] SPEED_REQ;
  logic [1:0] DTACK_SRC_n;
  logic       DTACK_PIN_n;
  logic       DTACK_OUT;
  logic       DTACK_OE;
  logic       FAST_DTACK_n;
  logic [0:0] CPU_SPEED;
  logic       SPEED_CHANGE;
  logic       DMAREQ_n;
  logic       AS_MB_EN;
  logic       BERR_n;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] src;
    logic       pin;
    logic       bgack;
    logic       halt;
    logic       exp_out;
    logic       exp_oe;
    logic       exp_asmb;
  } vec_t;

  vec_t vecs[8];

  bus_glue_ctrl dut (
    .C14M        (C14M),
    .RESET_n     (RESET_n),
    .C7M_EN      (c7m_en),
    .AS_CPU_n    (AS_CPU_n),
    .DS_n        (DS_n),
    .BG_n        (BG_n),
    .BGACK_n     (BGACK_n),
    .HALT_n      (HALT_n),
    .RAM_ACCESS  (RAM_ACCESS),
    .WAIT_STATES (WAIT_STATES),
    .SPEED_REQ   (SPEED_REQ),
    .DTACK_SRC_n (DTACK_SRC_n),
    .DTACK_PIN_n (DTACK_PIN_n),
    .DTACK_OUT   (DTACK_OUT),
    .DTACK_OE    (DTACK_OE),
    .FAST_DTACK_n(FAST_DTACK_n),
    .CPU_SPEED   (CPU_SPEED),
    .SPEED_CHANGE(SPEED_CHANGE),
    .DMAREQ_n    (DMAREQ_n),
    .AS_MB_EN    (AS_MB_EN),
    .BERR_n      (BERR_n)
  );

  initial C14M = 1'b0;
  always #5 C14M = ~C14M;

  // One C14M cycle; C7M_EN alternates so every other edge is a strobe edge
  task automatic tick();
    @(posedge C14M);
    #1;
    c7m_en = ~c7m_en;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " FAST_DTACK_n"}, 32'(FAST_DTACK_n), 32'd1);
    chk({tag, " CPU_SPEED"},    32'(CPU_SPEED),    32'd0);
    chk({tag, " SPEED_CHANGE"}, 32'(SPEED_CHANGE), 32'd0);
    chk({tag, " DMAREQ_n"},     32'(DMAREQ_n),     32'd1);
    chk({tag, " BERR_n"},       32'(BERR_n),       32'd1);
    chk({tag, " AS_MB_EN"},     32'(AS_MB_EN),     32'd1);
  endtask

  initial begin
    int pulses;

    //           src    pin   bgack halt  out   oe    asmb
    vecs[0] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    RESET_n = 1'b0; c7m_en = 1'b0; AS_CPU_n = 1'b1; DS_n = 1'b1;
    BG_n = 1'b1; BGACK_n = 1'b1; HALT_n = 1'b1; RAM_ACCESS = 1'b0;
    WAIT_STATES = 3'd0; SPEED_REQ = 1'b0; DTACK_SRC_n = 2'b11; DTACK_PIN_n = 1'b1;

    // Reset state
    repeat (3) tick();
    chk_reset_vals("reset");
    chk("reset DTACK_OE", 32'(DTACK_OE), 32'd0);
    RESET_n = 1'b1;
    tick();

    // DTACK merge, pin readback release and AS_MB_EN gating
    for (int i = 0; i < 8; i++) begin
      DTACK_SRC_n = vecs[i].src;
      DTACK_PIN_n = vecs[i].pin;
      BGACK_n     = vecs[i].bgack;
      HALT_n      = vecs[i].halt;
      tick();
      chk($sformatf("vec%0d DTACK_OUT", i), 32'(DTACK_OUT), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d DTACK_OE", i),  32'(DTACK_OE),  32'(vecs[i].exp_oe));
      chk($sformatf("vec%0d AS_MB_EN", i),  32'(AS_MB_EN),  32'(vecs[i].exp_asmb));
    end
    DTACK_SRC_n = 2'b11; DTACK_PIN_n = 1'b1; BGACK_n = 1'b1; HALT_n = 1'b1;
    tick();

    // Fast RAM, zero wait states: low on the second edge after DS_n sampled
    AS_CPU_n = 1'b0; RAM_ACCESS = 1'b1; WAIT_STATES = 3'd0; DS_n = 1'b0;
    tick(); chk("ws0 e+0", 32'(FAST_DTACK_n), 32'd1);
    tick(); chk("ws0 e+1", 32'(FAST_DTACK_n), 32'd1);
    tick(); chk("ws0 e+2", 32'(FAST_DTACK_n), 32'd0);
    chk("ws0 DTACK_OUT", 32'(DTACK_OUT), 32'd0);
    chk("ws0 DTACK_OE",  32'(DTACK_OE),  32'd1);
    DS_n = 1'b1;
    tick(); chk("ws0 ds rise +0", 32'(FAST_DTACK_n), 32'd0);
    tick(); chk("ws0 ds rise +1", 32'(FAST_DTACK_n), 32'd1);

    // Three wait states, DS_n released early: no assertion at all
    WAIT_STATES = 3'd3; DS_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("ws3 abort e+%0d", i), 32'(FAST_DTACK_n), 32'd1);
    end
    DS_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("ws3 after abort %0d", i), 32'(FAST_DTACK_n), 32'd1);
    end

    // One wait state from idle again: one extra cycle of latency
    WAIT_STATES = 3'd1; DS_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("ws1 e+%0d", i), 32'(FAST_DTACK_n), 32'd1);
    end
    tick(); chk("ws1 e+3", 32'(FAST_DTACK_n), 32'd0);
    DS_n = 1'b1;
    tick(); tick(); chk("ws1 released", 32'(FAST_DTACK_n), 32'd1);

    // Speed switch waits for the DTACK rise, then the next strobe
    RESET_n = 1'b0; AS_CPU_n = 1'b0; RAM_ACCESS = 1'b0; DTACK_SRC_n = 2'b11;
    tick(); tick();
    RESET_n = 1'b1; DTACK_SRC_n = 2'b10;
    tick(); tick();
    SPEED_REQ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("spd hold %0d CPU_SPEED", i), 32'(CPU_SPEED), 32'd0);
      chk($sformatf("spd hold %0d SPEED_CHANGE", i), 32'(SPEED_CHANGE), 32'd0);
    end
    if (c7m_en) tick();
    DTACK_SRC_n = 2'b11;
    tick();
    chk("spd rise CPU_SPEED", 32'(CPU_SPEED), 32'd0);
    chk("spd rise SPEED_CHANGE", 32'(SPEED_CHANGE), 32'd0);
    tick();
    chk("spd strobe CPU_SPEED", 32'(CPU_SPEED), 32'd1);
    chk("spd strobe SPEED_CHANGE", 32'(SPEED_CHANGE), 32'd1);
    tick();
    chk("spd after CPU_SPEED", 32'(CPU_SPEED), 32'd1);
    chk("spd pulse end", 32'(SPEED_CHANGE), 32'd0);

    // Request glitch with no boundary in between is ignored
    SPEED_REQ = 1'b0;
    tick(); tick();
    SPEED_REQ = 1'b1;
    tick(); tick();
    chk("glitch CPU_SPEED", 32'(CPU_SPEED), 32'd1);
    chk("glitch SPEED_CHANGE", 32'(SPEED_CHANGE), 32'd0);

    // Arbitration: grant during a CPU cycle parks in WAIT_IDLE
    BG_n = 1'b0;
    tick(); tick();
    chk("arb wait DMAREQ_n", 32'(DMAREQ_n), 32'd1);
    chk("arb wait AS_MB_EN", 32'(AS_MB_EN), 32'd1);
    if (c7m_en) tick();
    AS_CPU_n = 1'b1;
    tick();
    chk("arb non-strobe DMAREQ_n", 32'(DMAREQ_n), 32'd1);
    tick();
    chk("arb dma DMAREQ_n", 32'(DMAREQ_n), 32'd0);
    chk("arb dma AS_MB_EN", 32'(AS_MB_EN), 32'd0);
    BG_n = 1'b1;
    tick(); tick();
    chk("arb release DMAREQ_n", 32'(DMAREQ_n), 32'd1);
    chk("arb release AS_MB_EN", 32'(AS_MB_EN), 32'd1);
    BG_n = 1'b0;
    tick(); tick();
    chk("arb direct DMAREQ_n", 32'(DMAREQ_n), 32'd0);

    // Mid-activity reset: DMA owned, fast DTACK asserted, speed 1
    AS_CPU_n = 1'b0; DS_n = 1'b0; RAM_ACCESS = 1'b1; WAIT_STATES = 3'd0;
    tick(); tick(); tick();
    chk("pre-reset FAST_DTACK_n", 32'(FAST_DTACK_n), 32'd0);
    chk("pre-reset DMAREQ_n", 32'(DMAREQ_n), 32'd0);
    chk("pre-reset CPU_SPEED", 32'(CPU_SPEED), 32'd1);
    RESET_n = 1'b0;
    tick();
    chk_reset_vals("midreset");
    RESET_n = 1'b1; BG_n = 1'b1; AS_CPU_n = 1'b1; DS_n = 1'b1; RAM_ACCESS = 1'b0;

    // Idle bus (AS_CPU_n high) still provides a switch boundary
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (SPEED_CHANGE) pulses++;
    end
    chk("idle switch pulses", 32'(pulses), 32'd1);
    chk("idle switch CPU_SPEED", 32'(CPU_SPEED), 32'd1);

`ifdef BUS_TIMEOUT_EN
    // Strobed cycle with no DTACK times out after 1023 clocks
    AS_CPU_n = 1'b0;
    repeat (1022) tick();
    chk("timeout before", 32'(BERR_n), 32'd1);
    tick();
    chk("timeout BERR_n", 32'(BERR_n), 32'd0);
    AS_CPU_n = 1'b1;
    tick();
    chk("timeout cleared", 32'(BERR_n), 32'd1);
`else
    chk("BERR_n tied", 32'(BERR_n), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
